// File: rtl/gcd_sweep_driver_pkg.sv
// Shared definitions for the GCD sweep driver, its reference engine and the self-test wrapper.
package gcd_sweep_driver_pkg;

    localparam int unsigned DefUsize   = 6;
    localparam int unsigned DefVsize   = 5;
    localparam int unsigned DefTimeout = 32;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssue   = 3'd1,
        StWait    = 3'd2,
        StCompare = 3'd3,
        StNext    = 3'd4,
        StDone    = 3'd5
    } state_t;

endpackage

// File: rtl/gcd_sweep_driver_ref_euclid.sv
// Reference GCD by repeated subtraction; one subtraction per cycle, done is a one-cycle pulse.
module gcd_ref_euclid
    import gcd_sweep_driver_pkg::*;
#(
    parameter int unsigned USIZE = DefUsize
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [USIZE-1:0] a,
    input  logic [USIZE-1:0] b,
    output logic             done,
    output logic [USIZE-1:0] result
);

    logic [USIZE-1:0] a_q;
    logic [USIZE-1:0] b_q;
    logic             busy_q;

    // Load on start (restarting if already busy), then subtract until the operands agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q    <= a;
                b_q    <= b;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (a_q == '0) begin
                    result <= b_q;
                    done   <= 1'b1;
                    busy_q <= 1'b0;
                end else if ((b_q == '0) || (a_q == b_q)) begin
                    result <= a_q;
                    done   <= 1'b1;
                    busy_q <= 1'b0;
                end else if (a_q > b_q) begin
                    a_q <= a_q - b_q;
                end else begin
                    b_q <= b_q - a_q;
                end
            end
        end
    end

endmodule

// File: rtl/gcd_sweep_driver.sv
// Sweeps all (u,v) pairs through an external GCD core and checks each result against a
// subtraction-Euclid reference, counting passes and failures.
module gcd_sweep_driver
    import gcd_sweep_driver_pkg::*;
#(
    parameter int unsigned USIZE   = DefUsize,
    parameter int unsigned VSIZE   = DefVsize,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   core_start,
    output logic [USIZE-1:0]       core_u,
    output logic [VSIZE-1:0]       core_v,
    input  logic                   core_done,
    input  logic [USIZE-1:0]       core_gcd,
    output logic                   busy,
    output logic                   finished,
    output logic [USIZE+VSIZE:0]   pass_cnt,
    output logic [USIZE+VSIZE:0]   fail_cnt,
    output logic                   err_valid,
    output logic [USIZE-1:0]       err_u,
    output logic [VSIZE-1:0]       err_v,
    output logic [USIZE-1:0]       err_gcd
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [TW-1:0]    tmo_cnt;
    logic             core_have;
    logic [USIZE-1:0] core_res;
    logic             ref_have;
    logic [USIZE-1:0] ref_res;
    logic             ref_done;
    logic [USIZE-1:0] ref_result;

    logic             core_now;
    logic             ref_now;
    logic [USIZE-1:0] core_val;
    logic [USIZE-1:0] ref_val;
    logic             timeout_now;
    logic             fail_now;

    // The reference is started by the same registered pulse that starts the core.
    gcd_ref_euclid #(
        .USIZE (USIZE)
    ) u_ref (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .a      (core_u),
        .b      (USIZE'(core_v)),
        .done   (ref_done),
        .result (ref_result)
    );

    // Results either already captured or arriving this cycle; lets WAIT exit without a bubble.
    always_comb begin
        core_now    = core_have | core_done;
        ref_now     = ref_have | ref_done;
        core_val    = core_have ? core_res : core_gcd;
        ref_val     = ref_have ? ref_res : ref_result;
        timeout_now = !core_now && (tmo_cnt == TW'(TIMEOUT - 1));
        fail_now    = timeout_now || (core_val != ref_val);
    end

    // Sweep FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            tmo_cnt    <= '0;
            core_have  <= 1'b0;
            core_res   <= '0;
            ref_have   <= 1'b0;
            ref_res    <= '0;
            core_start <= 1'b0;
            core_u     <= '0;
            core_v     <= '0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_valid  <= 1'b0;
            err_u      <= '0;
            err_v      <= '0;
            err_gcd    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (run) begin
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        core_u     <= '0;
                        core_v     <= '0;
                        tmo_cnt    <= '0;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    // core_done here is deliberately not looked at.
                    core_start <= 1'b0;
                    core_have  <= 1'b0;
                    ref_have   <= 1'b0;
                    tmo_cnt    <= tmo_cnt + 1'b1;
                    state      <= StWait;
                end
                StWait: begin
                    if (core_done && !core_have) begin
                        core_have <= 1'b1;
                        core_res  <= core_gcd;
                    end
                    if (ref_done && !ref_have) begin
                        ref_have <= 1'b1;
                        ref_res  <= ref_result;
                    end
                    if (!core_now) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    // Verdict is registered on entry so COMPARE shows counts and err_valid.
                    if ((core_now && ref_now) || timeout_now) begin
                        state <= StCompare;
                        if (fail_now) begin
                            if (fail_cnt != '1) begin
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                            err_valid <= 1'b1;
                            err_u     <= core_u;
                            err_v     <= core_v;
                            err_gcd   <= timeout_now ? '0 : core_val;
                        end else if (pass_cnt != '1) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                end
                StCompare: begin
                    err_valid <= 1'b0;
                    state     <= StNext;
                end
                StNext: begin
                    if ((core_u == '1) && (core_v == '1)) begin
                        busy     <= 1'b0;
                        finished <= 1'b1;
                        state    <= StDone;
                    end else begin
                        core_v <= core_v + 1'b1;
                        if (core_v == '1) begin
                            core_u <= core_u + 1'b1;
                        end
                        tmo_cnt    <= '0;
                        core_start <= 1'b1;
                        state      <= StIssue;
                    end
                end
                StDone: begin
                    if (!run) begin
                        finished <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_sweep_driver.sv
// Directed bench for gcd_sweep_driver with a behavioural GCD core that can inject faults.
module tb_gcd_sweep_driver;

    localparam int unsigned USIZE = 6;
    localparam int unsigned VSIZE = 5;
    localparam int unsigned CW    = USIZE + VSIZE + 1;
    localparam int          LAT   = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             core_start;
    logic [USIZE-1:0] core_u;
    logic [VSIZE-1:0] core_v;
    logic             core_done;
    logic [USIZE-1:0] core_gcd;
    logic             busy;
    logic             finished;
    logic [CW-1:0]    pass_cnt;
    logic [CW-1:0]    fail_cnt;
    logic             err_valid;
    logic [USIZE-1:0] err_u;
    logic [VSIZE-1:0] err_v;
    logic [USIZE-1:0] err_gcd;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Fault injection controls for the behavioural core.
    bit fault_12_18 = 1'b0;
    bit drop_0_0    = 1'b0;
    bit early_63_31 = 1'b0;

    // Error-pulse monitor results.
    int err_seen = 0;
    int err_cyc  = 0;

    gcd_sweep_driver dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .core_start (core_start),
        .core_u     (core_u),
        .core_v     (core_v),
        .core_done  (core_done),
        .core_gcd   (core_gcd),
        .busy       (busy),
        .finished   (finished),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .err_valid  (err_valid),
        .err_u      (err_u),
        .err_v      (err_v),
        .err_gcd    (err_gcd)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gcd_mod(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_u"}, core_u, 0);
        check({tag, "_core_v"}, core_v, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finished"}, finished, 0);
        check({tag, "_pass_cnt"}, pass_cnt, 0);
        check({tag, "_fail_cnt"}, fail_cnt, 0);
        check({tag, "_err_valid"}, err_valid, 0);
        check({tag, "_err_u"}, err_u, 0);
        check({tag, "_err_v"}, err_v, 0);
        check({tag, "_err_gcd"}, err_gcd, 0);
    endtask

    // Behavioural core: answers LAT cycles after core_start, with optional faults.
    initial begin
        bit pend;
        int lat;
        int res;
        pend      = 1'b0;
        lat       = 0;
        res       = 0;
        core_done = 1'b0;
        core_gcd  = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    lat--;
                    if (lat == 0) begin
                        core_done = 1'b1;
                        core_gcd  = USIZE'(res);
                        pend      = 1'b0;
                    end
                end
                if (core_start) begin
                    res = gcd_mod(int'(core_u), int'(core_v));
                    if (fault_12_18 && core_u == 12 && core_v == 18) res = 3;
                    pend = !(drop_0_0 && core_u == 0 && core_v == 0);
                    lat  = LAT;
                    if (early_63_31 && core_u == 63 && core_v == 31) begin
                        core_done = 1'b1;
                        core_gcd  = 7;
                        lat       = 5;
                    end
                end
            end
        end
    end

    // Record every err_valid pulse.
    initial forever begin
        @(negedge clk);
        if (err_valid === 1'b1) begin
            err_seen++;
            err_cyc = cyc;
        end
    end

    initial begin
        int c0;
        int base;
        int k;
        bit hit;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start", core_start, 0);

        // Sweep 1: three core faults injected, run held high throughout.
        fault_12_18 = 1'b1;
        drop_0_0    = 1'b1;
        early_63_31 = 1'b1;
        base        = err_seen;
        run         = 1'b1;
        hit         = 1'b0;
        for (k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            hit = (core_start === 1'b1);
        end
        check("first_start_seen", hit, 1);
        c0 = cyc;
        check("first_pair_u", core_u, 0);
        check("first_pair_v", core_v, 0);
        check("busy_in_issue", busy, 1);

        hit = 1'b0;
        for (k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            hit = (err_seen > base);
        end
        check("timeout_err_seen", hit, 1);
        check("timeout_latency", err_cyc - c0, 32);
        check("timeout_err_u", err_u, 0);
        check("timeout_err_v", err_v, 0);
        check("timeout_err_gcd", err_gcd, 0);

        hit = 1'b0;
        for (k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            hit = (core_start === 1'b1);
        end
        check("after_timeout_start", hit, 1);
        check("after_timeout_u", core_u, 0);
        check("after_timeout_v", core_v, 1);

        hit = 1'b0;
        for (k = 0; k < 60000 && !hit; k++) begin
            @(negedge clk);
            hit = (finished === 1'b1);
        end
        check("sweep1_finished", hit, 1);
        check("sweep1_pass", pass_cnt, 2046);
        check("sweep1_fail", fail_cnt, 2);
        check("sweep1_err_pulses", err_seen - base, 2);
        check("sweep1_err_u", err_u, 12);
        check("sweep1_err_v", err_v, 18);
        check("sweep1_err_gcd", err_gcd, 3);
        check("sweep1_busy", busy, 0);

        // run still high in DONE: stay there with counts held.
        repeat (5) @(negedge clk);
        check("done_hold_finished", finished, 1);
        check("done_hold_pass", pass_cnt, 2046);
        check("done_hold_start", core_start, 0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_finished", finished, 0);
        check("idle_pass_kept", pass_cnt, 2046);
        check("idle_fail_kept", fail_cnt, 2);

        // Sweep 2: clean core, run dropped mid-sweep (ignored).
        fault_12_18 = 1'b0;
        drop_0_0    = 1'b0;
        early_63_31 = 1'b0;
        base        = err_seen;
        run         = 1'b1;
        @(negedge clk);
        check("sweep2_start", core_start, 1);
        check("sweep2_pass_clear", pass_cnt, 0);
        check("sweep2_fail_clear", fail_cnt, 0);
        check("sweep2_u", core_u, 0);
        check("sweep2_v", core_v, 0);
        repeat (50) @(negedge clk);
        run = 1'b0;
        check("sweep2_busy_mid", busy, 1);
        hit = 1'b0;
        for (k = 0; k < 60000 && !hit; k++) begin
            @(negedge clk);
            hit = (finished === 1'b1);
        end
        check("sweep2_finished", hit, 1);
        check("sweep2_pass", pass_cnt, 2048);
        check("sweep2_fail", fail_cnt, 0);
        check("sweep2_err_pulses", err_seen - base, 0);
        @(negedge clk);
        check("sweep2_back_idle", finished, 0);
        check("sweep2_pass_kept", pass_cnt, 2048);

        // Sweep 3: reset while pair (5,7) is being issued.
        run = 1'b1;
        hit = 1'b0;
        for (k = 0; k < 20000 && !hit; k++) begin
            @(negedge clk);
            hit = (core_start === 1'b1 && core_u == 5 && core_v == 7);
        end
        check("pair_5_7_seen", hit, 1);
        check("pass_before_rst", pass_cnt, 5 * 32 + 7);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_start", core_start, 1);
        check("restart_u", core_u, 0);
        check("restart_v", core_v, 0);
        check("restart_pass", pass_cnt, 0);
        check("restart_fail", fail_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
